// File: rtl/pwm_audio_out_if.sv
// rtl/pwm_audio_out_if.sv - sample handshake between sine lookup and audio output stage
interface pwm_audio_out_if;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       sample_ready;

  modport master (
    output sample_in,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/pwm_audio_out.sv
// rtl/pwm_audio_out.sv - double-buffered 8-bit sample to 1-bit PWM / sigma-delta pad driver
// One 255-clock frame per sample; mode and new sample both latch at the frame boundary.
module pwm_audio_out (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic                   mode,
  pwm_audio_out_if.slave         smp,
  output logic                   frame_start,
  output logic                   underrun,
  output logic                   dac_out
);

  logic [7:0] cnt;
  logic [7:0] hold;
  logic       hold_full;
  logic [7:0] act;
  logic       mode_act;
  logic [7:0] acc;
  logic       urun_pend;

  logic       accept;
  logic       boundary;
  logic [7:0] u;
  logic [8:0] sd_sum;

  assign u                = smp.sample_in ^ 8'h80;
  assign smp.sample_ready = !hold_full;
  assign accept           = smp.sample_valid && !hold_full;
  assign boundary         = ena && (cnt == 8'd254);
  assign frame_start      = ena && (cnt == 8'd0);
  assign underrun         = frame_start && urun_pend;
  assign sd_sum           = {1'b0, acc} + {1'b0, act};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 8'd0;
      hold      <= 8'd0;
      hold_full <= 1'b0;
      act       <= 8'h80;
      mode_act  <= 1'b0;
      acc       <= 8'd0;
      urun_pend <= 1'b0;
      dac_out   <= 1'b0;
    end else begin
      if (accept) begin
        hold <= u;
      end
      // A sample arriving on the boundary cycle itself goes straight to act below.
      if (accept && !boundary) begin
        hold_full <= 1'b1;
      end

      if (ena) begin
        if (mode_act) begin
          acc     <= sd_sum[7:0];
          dac_out <= sd_sum[8];
        end else begin
          dac_out <= (cnt < act);
        end

        if (boundary) begin
          cnt      <= 8'd0;
          mode_act <= mode;
          if (mode != mode_act) begin
            acc <= 8'd0;
          end
          if (hold_full) begin
            act       <= hold;
            hold_full <= 1'b0;
            urun_pend <= 1'b0;
          end else if (accept) begin
            act       <= u;
            urun_pend <= 1'b0;
          end else begin
            urun_pend <= 1'b1;
          end
        end else begin
          cnt <= cnt + 8'd1;
          // Underrun is reported once, on the enabled cnt == 0 cycle.
          if (cnt == 8'd0) begin
            urun_pend <= 1'b0;
          end
        end
      end else begin
        dac_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_audio_out.sv
// tb/tb_pwm_audio_out.sv - randomized and directed checks of pwm_audio_out against a frame-level model
module tb_pwm_audio_out;

  logic clk = 1'b0;
  logic rst;
  logic ena;
  logic mode;
  logic frame_start;
  logic underrun;
  logic dac_out;

  pwm_audio_out_if bus ();

  pwm_audio_out dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .mode        (mode),
    .smp         (bus),
    .frame_start (frame_start),
    .underrun    (underrun),
    .dac_out     (dac_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: position in frame, playing level, queued levels, sd integrator
  int m_cnt  = 0;
  int m_act  = 128;
  int m_hold[$];
  int m_mode = 0;
  int m_acc  = 0;
  int m_dac  = 0;
  int m_pend = 0;

  int ones      = 0;
  int last_ones = 0;
  int last_urun = 0;
  int seen_fs   = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int u;
    bit take;
    u    = int'(bus.sample_in ^ 8'h80);
    take = bus.sample_valid && (m_hold.size() == 0);
    if (rst) begin
      m_cnt = 0; m_act = 128; m_hold.delete(); m_mode = 0;
      m_acc = 0; m_dac = 0; m_pend = 0;
      return;
    end
    if (ena) begin
      if (m_mode != 0) begin
        m_dac = ((m_acc + m_act) >= 256) ? 1 : 0;
        m_acc = (m_acc + m_act) % 256;
      end else begin
        m_dac = (m_cnt < m_act) ? 1 : 0;
      end
      if (m_cnt == 254) begin
        m_cnt = 0;
        if (int'(mode) != m_mode) m_acc = 0;
        m_mode = int'(mode);
        if (m_hold.size() != 0) begin
          m_act = m_hold.pop_front();
          m_pend = 0;
        end else if (take) begin
          m_act = u;
          take = 0;
          m_pend = 0;
        end else begin
          m_pend = 1;
        end
      end else begin
        if (m_cnt == 0) m_pend = 0;
        m_cnt++;
      end
    end else begin
      m_dac = 0;
    end
    if (take) m_hold.push_back(u);
  endtask

  // Inputs are already driven; check at negedge, advance model, land just after posedge.
  task automatic tick();
    int e_fs;
    @(negedge clk);
    e_fs = (ena && m_cnt == 0) ? 1 : 0;
    chk("dac_out", dac_out, m_dac);
    chk("sample_ready", bus.sample_ready, (m_hold.size() == 0) ? 1 : 0);
    chk("frame_start", frame_start, e_fs);
    chk("underrun", underrun, (e_fs != 0 && m_pend != 0) ? 1 : 0);
    ones += int'(dac_out);
    if (frame_start === 1'b1) begin
      last_ones = ones;
      ones      = 0;
      last_urun = int'(underrun);
      seen_fs   = 1;
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_fs();
    int n;
    n = 0;
    seen_fs = 0;
    do begin
      tick();
      n++;
    end while (seen_fs == 0 && n < 600);
    chk("fs_timeout", seen_fs, 1);
  endtask

  task automatic wait_cnt(input int target);
    int n;
    n = 0;
    while (m_cnt != target && n < 600) begin
      tick();
      n++;
    end
    chk("cnt_timeout", m_cnt, target);
  endtask

  task automatic push(input logic [7:0] d);
    bus.sample_in    = d;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
  endtask

  initial begin
    int sd_ones;
    int dis_ones;
    rst = 1'b1; ena = 1'b0; mode = 1'b0;
    bus.sample_in = 8'h00; bus.sample_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus.sample_ready, 1);
    chk("rst_dac", dac_out, 0);
    chk("rst_urun", underrun, 0);
    chk("rst_fs", frame_start, 0);
    rst = 1'b0;
    ena = 1'b1;
    ones = 0;

    // idle: midscale frames with underrun at every frame start
    run_to_fs();
    run_to_fs();
    run_to_fs();
    chk("idle_ones", last_ones, 128);
    chk("idle_urun", last_urun, 1);

    // +127 pushed just before the boundary
    wait_cnt(250);
    push(8'h7F);
    run_to_fs();
    chk("max_no_urun", last_urun, 0);
    run_to_fs();
    chk("max_ones", last_ones, 255);

    // -127 then -128 on consecutive frames
    push(8'h81);
    run_to_fs();
    push(8'h80);
    run_to_fs();
    chk("m127_ones", last_ones, 1);
    run_to_fs();
    chk("m128_ones", last_ones, 0);

    // holding register full with valid held high
    bus.sample_in = 8'h11; bus.sample_valid = 1'b1;
    tick();
    chk("hold_ready_low", bus.sample_ready, 0);
    bus.sample_in = 8'h22;
    run_to_fs();
    bus.sample_valid = 1'b0;
    run_to_fs();
    chk("order_first", last_ones, 145);
    run_to_fs();
    chk("order_second", last_ones, 162);

    // sigma-delta at u = 192, then mode switched back mid-frame
    mode = 1'b1;
    push(8'h40);
    run_to_fs();
    sd_ones = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      sd_ones += int'(dac_out);
    end
    chk("sd_ones", sd_ones, 192);
    wait_cnt(120);
    mode = 1'b0;
    run_to_fs();
    run_to_fs();
    chk("pwm_after_sd", last_ones, 192);

    // disable mid-frame for 37 cycles, then reset mid-frame
    wait_cnt(100);
    ena = 1'b0;
    tick();
    dis_ones = 0;
    for (int i = 0; i < 37; i++) begin
      dis_ones += int'(dac_out);
      tick();
    end
    chk("dis_ones", dis_ones, 0);
    ena = 1'b1;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("post_rst_ready", bus.sample_ready, 1);
    chk("post_rst_dac", dac_out, 0);
    chk("post_rst_urun", underrun, 0);
    chk("post_rst_fs", frame_start, 1);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bus.sample_valid = ($urandom_range(0, 99) < 3);
      bus.sample_in    = 8'($urandom);
      if ($urandom_range(0, 299) == 0) mode = ~mode;
      ena = ($urandom_range(0, 19) != 0);
      rst = ($urandom_range(0, 1499) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
